regfile_2r1w: RTL and testbench
===============================

REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter: DATA_W, default 32, width of each register and of the data ports.
REQ-002 Parameter: ADDR_W, default 5, register index width, with 2**ADDR_W registers.
REQ-003 Clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 RegWrite  input  1  write enable for the write port.
REQ-006 WriteReg  input  ADDR_W  destination register index, driven by the datapath destination-register select (rt / rd / 31).
REQ-007 WriteData  input  DATA_W  write-back value.
REQ-008 ReadReg1  input  ADDR_W  read port 1 index.
REQ-009 ReadReg2  input  ADDR_W  read port 2 index.
REQ-010 ReadData1  output  DATA_W  read port 1 data.
REQ-011 ReadData2  output  DATA_W  read port 2 data.
REQ-012 WriteCount  output  16  number of committed writes since reset, excluding writes to register 0.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits.
REQ-014 A write SHALL commit on the rising Clk edge when RegWrite=1 and Rst_n=1: reg[WriteReg] <= WriteData.
REQ-015 A write with WriteReg=0 SHALL be discarded, and register 0 SHALL always read 0.
REQ-016 Reads SHALL be combinational, with zero latency from ReadRegN to ReadDataN.
REQ-017 Write-to-read latency without bypass SHALL be 1 cycle: a value written at edge k is visible on the read ports after edge k.
REQ-018 Both read ports SHALL be independent; equal indices on both ports SHALL return identical data.
REQ-019 WriteCount SHALL increment by 1 on each committed write to a nonzero index.
REQ-020 WriteCount SHALL saturate at 16'hFFFF with no wrap-around.
REQ-021 RegWrite=0 SHALL leave all state, including WriteCount, unchanged regardless of WriteReg and WriteData.
REQ-022 X or Z on WriteReg while RegWrite=0 SHALL NOT corrupt any register.

Reset
REQ-023 Rst_n=0 SHALL asynchronously clear all registers and WriteCount to 0, without waiting for a Clk edge.
REQ-024 While Rst_n=0, ReadData1 and ReadData2 SHALL read 0 for every index, and writes SHALL be ignored.
REQ-025 An edge on which Rst_n is low SHALL commit no write, including when a write is requested on the same edge reset asserts mid-operation.
REQ-026 Rst_n deassertion SHALL be synchronized by the integrator; the first edge with Rst_n=1 is the first edge on which a write can commit.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL control write-to-read bypass.
REQ-028 When REGFILE_BYPASS_EN is defined: if RegWrite=1, WriteReg!=0 and WriteReg==ReadRegN, ReadDataN SHALL equal WriteData in the same cycle, before the edge.
REQ-029 When REGFILE_BYPASS_EN is defined, bypass SHALL never apply to index 0 and SHALL be inactive while Rst_n=0.
REQ-030 When REGFILE_BYPASS_EN is undefined, ReadDataN SHALL show the pre-edge stored value, per REQ-017.
REQ-031 Write behaviour and WriteCount SHALL be identical in both builds.

Verification
REQ-032 Reset, then read indices 0..31 on both ports -> all 0; WriteCount=0.
REQ-033 Write 0xDEADBEEF to reg 31, then read reg 31 on both ports next cycle -> 0xDEADBEEF on both; WriteCount=1.
REQ-034 Write 0x12345678 to reg 0 -> ReadData of reg 0 stays 0; WriteCount unchanged.
REQ-035 Same-cycle write 0xA5A5A5A5 to reg 8 with ReadReg1=8 and old value 0x1 -> ReadData1=0xA5A5A5A5 before the edge with REGFILE_BYPASS_EN, and 0x1 without it; 0xA5A5A5A5 after the edge in both builds.
REQ-036 Write 0x55 to reg 3, then assert Rst_n=0 mid-cycle between edges -> ReadData of reg 3 drops to 0 immediately; a write requested during reset is not committed; WriteCount=0.
REQ-037 Preload WriteCount to 0xFFFE through 0xFFFE writes, then perform 3 more writes -> WriteCount reads 0xFFFF and holds.

Source files
------------

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two-read one-write register file with hard-wired zero register and saturating write counter
// Ports: Clk, Rst_n (async active-low clear of all state)
//        RegWrite/WriteReg/WriteData - write port, commits on rising Clk
//        ReadReg1/ReadReg2 -> ReadData1/ReadData2 - combinational read ports
//        WriteCount - saturating count of committed writes to nonzero indices
// Build option: define REGFILE_BYPASS_EN to forward same-cycle WriteData to matching read ports
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [15:0]       WriteCount
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic commit, byp1, byp2;
    // RegWrite gates first so an undriven WriteReg during idle cycles cannot select a register
    assign commit = RegWrite && (WriteReg != '0);
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[WriteReg] <= WriteData;
        end
    end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) WriteCount <= '0;
        else if (commit && WriteCount != 16'hFFFF) WriteCount <= WriteCount + 16'd1;
    end
`ifdef REGFILE_BYPASS_EN
    assign byp1 = Rst_n && commit && (WriteReg == ReadReg1);
    assign byp2 = Rst_n && commit && (WriteReg == ReadReg2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif
    // Register 0 is never written and is cleared on reset, so it always reads zero
    assign ReadData1 = byp1 ? WriteData : regs[ReadReg1];
    assign ReadData2 = byp2 ? WriteData : regs[ReadReg2];
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: table-driven directed checks for regfile_2r1w
module tb_regfile_2r1w;
    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteReg = '0;
    logic [31:0] WriteData = '0;
    logic [4:0]  ReadReg1 = '0;
    logic [4:0]  ReadReg2 = '0;
    logic [31:0] ReadData1, ReadData2;
    logic [15:0] WriteCount;
    int passCount = 0;
    int totalCount = 0;

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteCount(WriteCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passCount++;
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        tbl[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd31, 32'h0,        32'hDEADBEEF, 16'd1};
        tbl[2] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd0,  32'h0,        32'h0,        16'd1};
        tbl[3] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd31, 32'hCAFEF00D, 32'hDEADBEEF, 16'd2};
        tbl[4] = '{1'b1, 5'd8,  32'h00000001, 5'd8,  5'd5,  32'h1,        32'hCAFEF00D, 16'd3};
        tbl[5] = '{1'b1, 5'd31, 32'h00000000, 5'd31, 5'd8,  32'h0,        32'h1,        16'd4};
        tbl[6] = '{1'b1, 5'd1,  32'hAAAA5555, 5'd1,  5'd1,  32'hAAAA5555, 32'hAAAA5555, 16'd5};
        tbl[7] = '{1'b0, 5'd1,  32'h00000000, 5'd1,  5'd5,  32'hAAAA5555, 32'hCAFEF00D, 16'd5};

        // reset held low: every index reads zero on both ports
        #2;
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_rd1_%0d", i), ReadData1, 32'h0);
            chk($sformatf("rst_rd2_%0d", 31 - i), ReadData2, 32'h0);
        end
        chk("rst_count", 32'(WriteCount), 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // table: one write cycle, then read back with write disabled
        for (int v = 0; v < 8; v++) begin
            @(negedge Clk);
            RegWrite = tbl[v].we;
            WriteReg = tbl[v].wr;
            WriteData = tbl[v].wd;
            @(negedge Clk);
            RegWrite = 1'b0;
            WriteReg = 'x;
            WriteData = 'x;
            ReadReg1 = tbl[v].r1;
            ReadReg2 = tbl[v].r2;
            #1;
            chk($sformatf("vec%0d_rd1", v), ReadData1, tbl[v].e1);
            chk($sformatf("vec%0d_rd2", v), ReadData2, tbl[v].e2);
            chk($sformatf("vec%0d_count", v), 32'(WriteCount), 32'(tbl[v].ec));
        end

        // same-cycle write/read of reg 8 (old value 1)
        @(negedge Clk);
        RegWrite = 1'b1;
        WriteReg = 5'd8;
        WriteData = 32'hA5A5A5A5;
        ReadReg1 = 5'd8;
        ReadReg2 = 5'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_pre_edge", ReadData1, 32'hA5A5A5A5);
`else
        chk("same_cycle_pre_edge", ReadData1, 32'h1);
`endif
        chk("same_cycle_rd2_zero", ReadData2, 32'h0);
        @(negedge Clk);
        RegWrite = 1'b0;
        #1;
        chk("same_cycle_post_edge", ReadData1, 32'hA5A5A5A5);
        chk("same_cycle_count", 32'(WriteCount), 32'd6);

        // write to reg 0 while reading reg 0: never forwarded, never stored
        @(negedge Clk);
        RegWrite = 1'b1;
        WriteReg = 5'd0;
        WriteData = 32'hFFFFFFFF;
        ReadReg1 = 5'd0;
        #1;
        chk("reg0_pre_edge", ReadData1, 32'h0);
        @(negedge Clk);
        RegWrite = 1'b0;
        #1;
        chk("reg0_post_edge", ReadData1, 32'h0);
        chk("reg0_count", 32'(WriteCount), 32'd6);

        // write reg 3 then reset mid-cycle
        @(negedge Clk);
        RegWrite = 1'b1;
        WriteReg = 5'd3;
        WriteData = 32'h55;
        @(negedge Clk);
        RegWrite = 1'b0;
        ReadReg1 = 5'd3;
        #1;
        chk("r3_written", ReadData1, 32'h55);
        chk("r3_count", 32'(WriteCount), 32'd7);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst_r3", ReadData1, 32'h0);
        chk("async_rst_count", 32'(WriteCount), 32'h0);
        RegWrite = 1'b1;
        WriteReg = 5'd4;
        WriteData = 32'h77;
        ReadReg2 = 5'd4;
        #1;
        chk("rst_no_bypass", ReadData2, 32'h0);
        @(negedge Clk);
        RegWrite = 1'b0;
        Rst_n = 1'b1;
        #1;
        chk("rst_write_dropped", ReadData2, 32'h0);
        chk("rst_write_count", 32'(WriteCount), 32'h0);

        // saturation: 0xFFFE writes, then three more
        @(negedge Clk);
        RegWrite = 1'b1;
        WriteReg = 5'd2;
        WriteData = 32'h1;
        repeat (65534) @(negedge Clk);
        RegWrite = 1'b0;
        #1;
        chk("preload_count", 32'(WriteCount), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            RegWrite = 1'b1;
            @(negedge Clk);
            RegWrite = 1'b0;
            #1;
            chk($sformatf("sat_count_%0d", k), 32'(WriteCount), 32'hFFFF);
        end
        repeat (2) @(negedge Clk);
        chk("sat_hold", 32'(WriteCount), 32'hFFFF);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
